// File: rtl/dmem_lsu_if.sv
// SRAM-side bus of the load/store unit.
// The LSU drives the master modport; the word SRAM drives mem_rdata.
interface dmem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 7
);
  logic              mem_re;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit between EX/MEM and a word-organised synchronous SRAM.
// Word stores take one cycle; loads and SB/SH take two (read-modify-write).
module dmem_lsu #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  stall,
  output logic                  err,
  dmem_lsu_if.master            mem
);

  typedef enum logic [1:0] {
    IDLE,
    LD_RESP,
    ST_MERGE
  } state_t;

  state_t state, state_nxt;

  logic              is_half, is_word;
  logic              misal, ld_ok, st_ok;
  logic              illegal, bad;
  logic              re, we;
  logic [4:0]        bsh;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] wdata;

  assign is_half = (func3[1:0] == 2'b01);
  assign is_word = (func3[1:0] == 2'b10);
  assign misal   = (is_half & addr[0]) |
                   (is_word & (addr[1:0] != 2'b00));
  assign ld_ok   = func3 inside {3'b000, 3'b001, 3'b010,
                                 3'b100, 3'b101};
  assign st_ok   = func3 inside {3'b000, 3'b001, 3'b010};

  assign illegal = (MemRead & MemWrite) |
                   ((MemRead | MemWrite) &
                    (misal | (MemRead & ~ld_ok) |
                     (MemWrite & ~st_ok)));

  assign bsh  = {addr[1:0], 3'b000};
  assign bsel = mem.mem_rdata[bsh +: 8];
  assign hsel = addr[1] ? mem.mem_rdata[31:16]
                        : mem.mem_rdata[15:0];

  always_comb begin
    ld_ext = mem.mem_rdata;
    unique case (func3)
      3'b000:  ld_ext = {{24{bsel[7]}}, bsel};
      3'b001:  ld_ext = {{16{hsel[15]}}, hsel};
      3'b100:  ld_ext = {24'h0, bsel};
      3'b101:  ld_ext = {16'h0, hsel};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem.mem_rdata;
    if (func3[0]) begin
      if (addr[1]) merged[31:16] = wr_data[15:0];
      else         merged[15:0]  = wr_data[15:0];
    end else begin
      merged[bsh +: 8] = wr_data[7:0];
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    re        = 1'b0;
    we        = 1'b0;
    bad       = 1'b0;
    wdata     = wr_data;
    unique case (state)
      IDLE: begin
        if (illegal) begin
          bad = 1'b1;
        end else if (MemWrite && func3 == 3'b010) begin
          we = 1'b1;
        end else if (MemRead) begin
          re        = 1'b1;
          stall     = 1'b1;
          state_nxt = LD_RESP;
        end else if (MemWrite) begin
          re        = 1'b1;
          stall     = 1'b1;
          state_nxt = ST_MERGE;
        end
      end
      LD_RESP: state_nxt = IDLE;
      ST_MERGE: begin
        we        = 1'b1;
        wdata     = merged;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset kills strobes at once so an in-flight merge never writes.
    if (reset) begin
      state_nxt = IDLE;
      stall     = 1'b0;
      re        = 1'b0;
      we        = 1'b0;
      bad       = 1'b0;
    end
  end

  assign mem.mem_re    = re;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr[DM_ADDRESS-1:2];
  assign mem.mem_wdata = wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= bad;
      if (state == LD_RESP) rd_data <= ld_ext;
    end
  end

endmodule
